pbuf_port_arbiter: RTL and testbench

Parametrised N-channel arbiter for the single port of the integrity path buffer. It generalises the fixed Dec/Stash/header/AES multiplexing to NumChan requesters, each granted a burst run of BurstsPerGrant accesses at its own base address. Read-side (buffer-to-AES) issue is gated by a downstream credit counter, and read data is tagged with the owning channel after a fixed latency. It sits between the integrity datapath sources and the path buffer RAM.

---
 rtl/pbuf_port_arbiter.sv | 130 +++++++++++++
 tb/tb_pbuf_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pbuf_port_arbiter.sv
// pbuf_port_arbiter: N-channel burst arbiter for the single path buffer port
// Each grant runs BurstsPerGrant accesses from a latched base; reads are credit-gated and channel-tagged.
module pbuf_port_arbiter #(
    parameter int DWidth         = 512,
    parameter int NumChan        = 4,
    parameter int AWidth         = 8,
    parameter int BurstsPerGrant = 6,
    parameter int ReadLatency    = 1,
    parameter int RRMode         = 1,
    parameter int CreditDepth    = 2
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NumChan-1:0]         ChanReq,
    input  logic [NumChan-1:0]         ChanWrite,
    input  logic [NumChan*AWidth-1:0]  ChanBase,
    input  logic [NumChan*DWidth-1:0]  ChanData,
    input  logic [NumChan-1:0]         ChanValid,
    output logic [NumChan-1:0]         ChanAck,
    output logic [NumChan-1:0]         ChanDone,
    output logic                       Enable,
    output logic                       Write,
    output logic [AWidth-1:0]          Address,
    output logic [DWidth-1:0]          DIn,
    input  logic                       CreditReturn,
    output logic                       DOutValid,
    output logic [$clog2(NumChan)-1:0] DOutChan,
    output logic                       CreditErr
);
    localparam int ChanWidth = $clog2(NumChan);
    localparam int CtrWidth  = $clog2(BurstsPerGrant + 1);
    localparam int CredWidth = $clog2(CreditDepth + 1);

    typedef enum logic {Idle, Grant} state_t;

    state_t                 state;
    logic [ChanWidth-1:0]   grantIdx;
    logic [ChanWidth-1:0]   rrPtr;
    logic [ChanWidth-1:0]   basePtr;
    logic [ChanWidth-1:0]   cand;
    logic [ChanWidth-1:0]   winner;
    logic                   grantDir;
    logic [AWidth-1:0]      grantBase;
    logic [CtrWidth-1:0]    burstCtr;
    logic [CredWidth-1:0]   credits;
    logic [ReadLatency-1:0] tagValid;
    logic [ChanWidth-1:0]   tagChan [ReadLatency];
    logic [AWidth-1:0]      baseArr [NumChan];
    logic [DWidth-1:0]      dataArr [NumChan];
    logic                   inGrant;
    logic                   lastBurst;
    logic                   readIssue;

    for (genvar i = 0; i < NumChan; i++) begin : gSplit
        assign baseArr[i] = ChanBase[i*AWidth +: AWidth];
        assign dataArr[i] = ChanData[i*DWidth +: DWidth];
    end

    // Scan from the highest offset down so the requester nearest the pointer wins last.
    assign basePtr = RRMode != 0 ? rrPtr : '0;
    always_comb begin
        winner = '0;
        cand = '0;
        for (int k = NumChan - 1; k >= 0; k--) begin
            cand = ChanWidth'((int'(basePtr) + k) % NumChan);
            winner = ChanReq[cand] ? cand : winner;
        end
    end

    assign inGrant   = state == Grant;
    assign Enable    = inGrant & (grantDir ? ChanValid[grantIdx] : credits != '0);
    assign Write     = inGrant & grantDir;
    assign Address   = grantBase + AWidth'(burstCtr);
    assign DIn       = Write ? dataArr[grantIdx] : '0;
    assign lastBurst = Enable && burstCtr == CtrWidth'(BurstsPerGrant - 1);
    assign readIssue = Enable & ~grantDir;
    assign DOutValid = tagValid[ReadLatency-1];
    assign DOutChan  = tagChan[ReadLatency-1];

    always_comb begin
        ChanAck = '0;
        ChanDone = '0;
        ChanAck[grantIdx] = Enable;
        ChanDone[grantIdx] = lastBurst;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= Idle;
            grantIdx <= '0;
            grantDir <= 1'b0;
            grantBase <= '0;
            burstCtr <= '0;
            rrPtr <= '0;
            credits <= CredWidth'(CreditDepth);
            CreditErr <= 1'b0;
            tagValid <= '0;
            for (int i = 0; i < ReadLatency; i++) tagChan[i] <= '0;
        end else begin
            if (!inGrant && ChanReq != '0) begin
                state <= Grant;
                grantIdx <= winner;
                grantDir <= ChanWrite[winner];
                grantBase <= baseArr[winner];
                burstCtr <= '0;
            end else if (Enable) begin
                burstCtr <= burstCtr + 1'b1;
                if (lastBurst) begin
                    state <= Idle;
                    rrPtr <= grantIdx == ChanWidth'(NumChan - 1) ? '0 : grantIdx + 1'b1;
                end
            end
            // A return against a full counter is an upstream protocol error, not a new slot.
            if (readIssue && !CreditReturn)
                credits <= credits - 1'b1;
            else if (!readIssue && CreditReturn) begin
                if (credits == CredWidth'(CreditDepth))
                    CreditErr <= 1'b1;
                else
                    credits <= credits + 1'b1;
            end
            tagValid[0] <= readIssue;
            tagChan[0] <= readIssue ? grantIdx : tagChan[0];
            for (int i = 1; i < ReadLatency; i++) begin
                tagValid[i] <= tagValid[i-1];
                tagChan[i] <= tagChan[i-1];
            end
        end
    end
endmodule

// File: tb/tb_pbuf_port_arbiter.sv
// tb_pbuf_port_arbiter: vector tables, directed corner sequences and a random run against a grant-level model.
module tb_pbuf_port_arbiter;
    localparam int N = 4, DW = 512, AW = 8, BPG = 6, RL = 1, CD = 2;

    logic              Clock, Reset;
    logic [N-1:0]      ChanReq, ChanWrite, ChanValid;
    logic [N*AW-1:0]   ChanBase;
    logic [N*DW-1:0]   ChanData;
    logic              CreditReturn;
    logic [N-1:0]      ChanAck, ChanDone, fpAck, fpDone;
    logic              Enable, Write, fpEnable, fpWrite;
    logic [AW-1:0]     Address, fpAddress;
    logic [DW-1:0]     DIn, fpDIn;
    logic              DOutValid, fpDOutValid, CreditErr, fpCreditErr;
    logic [1:0]        DOutChan, fpDOutChan;

    int checks = 0, errors = 0;

    pbuf_port_arbiter #(.DWidth(DW), .NumChan(N), .AWidth(AW), .BurstsPerGrant(BPG),
        .ReadLatency(RL), .RRMode(1), .CreditDepth(CD)) dut (
        .Clock(Clock), .Reset(Reset), .ChanReq(ChanReq), .ChanWrite(ChanWrite), .ChanBase(ChanBase),
        .ChanData(ChanData), .ChanValid(ChanValid), .ChanAck(ChanAck), .ChanDone(ChanDone),
        .Enable(Enable), .Write(Write), .Address(Address), .DIn(DIn), .CreditReturn(CreditReturn),
        .DOutValid(DOutValid), .DOutChan(DOutChan), .CreditErr(CreditErr));

    pbuf_port_arbiter #(.DWidth(DW), .NumChan(N), .AWidth(AW), .BurstsPerGrant(BPG),
        .ReadLatency(RL), .RRMode(0), .CreditDepth(CD)) dutFp (
        .Clock(Clock), .Reset(Reset), .ChanReq(ChanReq), .ChanWrite(ChanWrite), .ChanBase(ChanBase),
        .ChanData(ChanData), .ChanValid(ChanValid), .ChanAck(fpAck), .ChanDone(fpDone),
        .Enable(fpEnable), .Write(fpWrite), .Address(fpAddress), .DIn(fpDIn), .CreditReturn(CreditReturn),
        .DOutValid(fpDOutValid), .DOutChan(fpDOutChan), .CreditErr(fpCreditErr));

    initial Clock = 0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idleInputs();
        ChanReq = '0;
        ChanWrite = '0;
        ChanValid = '0;
        CreditReturn = 0;
    endtask

    task automatic doReset();
        idleInputs();
        Reset = 0;
        tick();
        tick();
        Reset = 1;
    endtask

    // Grant-level reference: who owns the port, how many bursts are done, credits and in-flight tags.
    typedef struct { int due; int ch; } tag_t;
    tag_t        tq[$];
    bit          mBusy, mDir, mErr, expEn;
    int          mOwner, mBase, mDone, mPtr, mCredits, cyc;

    task automatic modelReset();
        mBusy = 0; mDir = 0; mErr = 0; mOwner = 0; mBase = 0; mDone = 0;
        mPtr = 0; mCredits = CD; tq.delete();
    endtask

    task automatic modelCheck();
        logic [N-1:0]  ackE, doneE;
        logic [DW-1:0] dinE;
        bit            wrE, dvE;
        expEn = mBusy && (mDir ? ChanValid[mOwner] : mCredits > 0);
        wrE = mBusy && mDir;
        ackE = expEn ? N'(1) << mOwner : '0;
        doneE = (expEn && mDone == BPG - 1) ? N'(1) << mOwner : '0;
        dinE = wrE ? ChanData[mOwner*DW +: DW] : '0;
        dvE = tq.size() > 0 && tq[0].due == cyc;
        check("rand enable", Enable, expEn);
        check("rand write", Write, wrE);
        check("rand address", Address, (mBase + mDone) % 256);
        check("rand ack", ChanAck, ackE);
        check("rand done", ChanDone, doneE);
        check("rand din", DIn === dinE, 1);
        check("rand doutvalid", DOutValid, dvE);
        check("rand crediterr", CreditErr, mErr);
        if (dvE) check("rand doutchan", DOutChan, tq[0].ch);
    endtask

    task automatic modelUpdate();
        bit issue;
        if (!Reset) begin
            modelReset();
        end else begin
            if (tq.size() > 0 && tq[0].due == cyc) void'(tq.pop_front());
            issue = expEn && !mDir;
            if (issue) tq.push_back('{cyc + RL, mOwner});
            if (issue && !CreditReturn) mCredits--;
            else if (!issue && CreditReturn) begin
                if (mCredits == CD) mErr = 1;
                else mCredits++;
            end
            if (!mBusy) begin
                for (int k = 0; k < N; k++) begin
                    int idx = (mPtr + k) % N;
                    if (ChanReq[idx]) begin
                        mBusy = 1; mOwner = idx; mDir = ChanWrite[idx];
                        mBase = ChanBase[idx*AW +: AW]; mDone = 0;
                        break;
                    end
                end
            end else if (expEn) begin
                mDone++;
                if (mDone == BPG) begin
                    mBusy = 0;
                    mPtr = (mOwner + 1) % N;
                end
            end
        end
        cyc++;
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic          valid;
        logic          expEn;
        logic          expWr;
        logic [AW-1:0] expAddr;
        logic [N-1:0]  expDone;
    } vec_t;

    vec_t wrVec[9];
    int   rrSeen[$], fpSeen[$];
    int   rrExp[5] = '{0, 1, 2, 3, 0};
    int   wrapExp[6] = '{'hFE, 'hFF, 'h00, 'h01, 'h02, 'h03};
    int   wrapSeen[$];
    logic [N-1:0] lastDone;
    logic [11:0]  crEn, crDv, crRet;
    logic [3:0]   simEn;

    initial begin
        wrVec = '{
            '{4'b0010, 0, 0, 0, 8'h00, 4'b0000},
            '{4'b0000, 1, 1, 1, 8'h10, 4'b0000},
            '{4'b0000, 1, 1, 1, 8'h11, 4'b0000},
            '{4'b0000, 0, 0, 1, 8'h12, 4'b0000},
            '{4'b0000, 1, 1, 1, 8'h12, 4'b0000},
            '{4'b0000, 1, 1, 1, 8'h13, 4'b0000},
            '{4'b0000, 1, 1, 1, 8'h14, 4'b0000},
            '{4'b0000, 1, 1, 1, 8'h15, 4'b0010},
            '{4'b0000, 1, 0, 0, 8'h16, 4'b0000}};
        crEn  = 12'b0010_0000_0110;
        crDv  = 12'b0100_0000_1100;
        crRet = 12'b0001_0000_0000;
        simEn = 4'b0111;
        ChanBase = '0;
        ChanData = '0;

        doReset();
        #4;
        check("reset enable", Enable, 0);
        check("reset write", Write, 0);
        check("reset address", Address, 0);
        check("reset din", |DIn, 0);
        check("reset ack", ChanAck, 0);
        check("reset done", ChanDone, 0);
        check("reset doutvalid", DOutValid, 0);
        check("reset doutchan", DOutChan, 0);
        check("reset crediterr", CreditErr, 0);
        tick();

        ChanWrite = 4'b0010;
        ChanBase[1*AW +: AW] = 8'h10;
        for (int w = 0; w < N*DW/32; w++) ChanData[w*32 +: 32] = $urandom;
        for (int i = 0; i < 9; i++) begin
            ChanReq = wrVec[i].req;
            ChanValid = {2'b00, wrVec[i].valid, 1'b0};
            #4;
            check($sformatf("wr enable %0d", i), Enable, wrVec[i].expEn);
            check($sformatf("wr write %0d", i), Write, wrVec[i].expWr);
            check($sformatf("wr address %0d", i), Address, wrVec[i].expAddr);
            check($sformatf("wr ack %0d", i), ChanAck, wrVec[i].expEn ? 4'b0010 : 4'b0000);
            check($sformatf("wr done %0d", i), ChanDone, wrVec[i].expDone);
            check($sformatf("wr din %0d", i), DIn === (wrVec[i].expWr ? ChanData[1*DW +: DW] : '0), 1);
            tick();
        end

        doReset();
        ChanReq = 4'b1111;
        ChanWrite = 4'b1111;
        ChanValid = 4'b1111;
        for (int c = 0; c < 60 && (rrSeen.size() < 5 || fpSeen.size() < 5); c++) begin
            #4;
            for (int i = 0; i < N; i++) begin
                if (ChanDone[i]) rrSeen.push_back(i);
                if (fpDone[i]) fpSeen.push_back(i);
            end
            tick();
        end
        check("rr grant count", rrSeen.size() >= 5, 1);
        check("fp grant count", fpSeen.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr order %0d", i), i < rrSeen.size() ? rrSeen[i] : -1, rrExp[i]);
            check($sformatf("fp order %0d", i), i < fpSeen.size() ? fpSeen[i] : -1, 0);
        end

        doReset();
        ChanBase[2*AW +: AW] = 8'h40;
        for (int c = 0; c < 12; c++) begin
            ChanReq = c == 0 ? 4'b0100 : 4'b0000;
            CreditReturn = crRet[c];
            #4;
            check($sformatf("credit enable %0d", c), Enable, crEn[c]);
            check($sformatf("credit doutvalid %0d", c), DOutValid, crDv[c]);
            check($sformatf("credit done %0d", c), ChanDone, 0);
            if (crDv[c]) check($sformatf("credit doutchan %0d", c), DOutChan, 2);
            tick();
        end

        doReset();
        for (int c = 0; c < 5; c++) begin
            ChanReq = c == 0 ? 4'b0001 : 4'b0000;
            CreditReturn = c == 2;
            #4;
            if (c > 0) check($sformatf("simul enable %0d", c), Enable, simEn[c-1]);
            tick();
        end

        doReset();
        ChanReq = 4'b0001;
        tick();
        ChanReq = 4'b0000;
        #4;
        check("midreset enable", Enable, 1);
        Reset = 0;
        tick();
        Reset = 1;
        #4;
        check("midreset doutvalid", DOutValid, 0);
        check("midreset done", ChanDone, 0);
        check("midreset enable after", Enable, 0);
        tick();

        doReset();
        ChanReq = 4'b1000;
        ChanWrite = 4'b1000;
        ChanValid = 4'b1111;
        ChanBase[3*AW +: AW] = 8'hFE;
        lastDone = '0;
        for (int c = 0; c < 10; c++) begin
            #4;
            if (Enable) begin
                wrapSeen.push_back(Address);
                lastDone = ChanDone;
            end
            tick();
            ChanReq = '0;
        end
        check("wrap count", wrapSeen.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("wrap address %0d", i), i < wrapSeen.size() ? wrapSeen[i] : -1, wrapExp[i]);
        check("wrap last done", lastDone, 4'b1000);

        doReset();
        #4;
        check("crediterr clear", CreditErr, 0);
        CreditReturn = 1;
        tick();
        CreditReturn = 0;
        #4;
        check("crediterr set", CreditErr, 1);
        repeat (5) tick();
        #4;
        check("crediterr sticky", CreditErr, 1);
        doReset();
        #4;
        check("crediterr after reset", CreditErr, 0);
        tick();

        doReset();
        modelReset();
        cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            Reset = $urandom_range(0, 199) != 0;
            ChanReq = N'($urandom);
            ChanWrite = N'($urandom);
            ChanValid = N'($urandom | $urandom);
            ChanBase = (N*AW)'($urandom);
            for (int w = 0; w < N*DW/32; w++) ChanData[w*32 +: 32] = $urandom;
            CreditReturn = $urandom_range(0, 2) == 0;
            #4;
            modelCheck();
            modelUpdate();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
